// File: rtl/beta_if_stage_pkg.sv
// Shared types and constants for the beta instruction fetch stage.
// Build option: BETA_IF_MISALIGN_CHECK_EN enables misaligned-redirect trapping.
package beta_if_stage_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IF_IDLE   = 2'd0,
      IF_REQ    = 2'd1,
      IF_WAIT   = 2'd2,
      IF_ISSUED = 2'd3
   } if_state_t;

   localparam logic [31:0] IF_BOOT_ADDR = 32'h0000_0080;
   localparam logic [31:0] IF_PC_INC    = 32'd4;

endpackage

// File: rtl/beta_if_pc_gen.sv
// Fetch PC register with sequential-increment / redirect selection.
// Build option: BETA_IF_MISALIGN_CHECK_EN keeps the low target bits and flags
// misaligned redirects; otherwise redirect targets are forced word-aligned.
module beta_if_pc_gen
   import beta_if_stage_pkg::*;
#(
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] BootAddr  = IF_BOOT_ADDR
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 advance_i,
   input  logic                 jump_en_i,
   input  logic [DataWidth-1:0] jump_target_i,
`ifdef BETA_IF_MISALIGN_CHECK_EN
   output logic                 misaligned_o,
`endif
   output logic [DataWidth-1:0] pc_o
);

   logic [DataWidth-1:0] pc_q;
   logic [DataWidth-1:0] pc_d;
   logic [DataWidth-1:0] target_sel;

`ifdef BETA_IF_MISALIGN_CHECK_EN
   assign target_sel   = jump_target_i;
   assign misaligned_o = jump_en_i && (jump_target_i[1:0] != 2'b00);
`else
   // Clear the byte-offset bits so every fetch stays word-aligned
   assign target_sel = jump_target_i & {{(DataWidth-2){1'b1}}, 2'b00};
`endif

   // Next PC: hold, redirect (wins over sequential) or wrap-around increment
   always_comb begin
      pc_d = pc_q;
      if (advance_i) begin
         pc_d = jump_en_i ? target_sel : (pc_q + IF_PC_INC);
      end
   end

   // PC register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= BootAddr;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/beta_if_stage.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid master that
// registers the returned word and hands it to decode with a one-cycle pulse.
// Build option: BETA_IF_MISALIGN_CHECK_EN adds if_misaligned_o.
module beta_if_stage
   import beta_if_stage_pkg::*;
#(
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] BootAddr  = IF_BOOT_ADDR
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 if_fetch_en_i,
   output logic                 if_imem_req_o,
   output logic [DataWidth-1:0] if_imem_addr_o,
   input  logic                 if_imem_gnt_i,
   input  logic                 if_imem_rvalid_i,
   input  logic [DataWidth-1:0] if_imem_rdata_i,
   input  logic                 if_imem_err_i,
   output logic [DataWidth-1:0] if_instr_o,
   output logic [DataWidth-1:0] if_pc_o,
   output logic [DataWidth-1:0] if_next_pc_o,
   output logic                 if_new_instr_o,
   output logic                 if_fetch_err_o,
   input  logic                 if_fetch_next_i,
   input  logic                 if_jump_en_i,
   input  logic [DataWidth-1:0] if_jump_target_i,
`ifdef BETA_IF_MISALIGN_CHECK_EN
   output logic                 if_misaligned_o,
`endif
   output logic                 if_stage_busy_o
);

   // Handshake: the request (req_o/addr_o) is held until gnt_i is seen high
   // on a rising edge; rvalid_i is only honoured in WAIT, i.e. no earlier
   // than the cycle after gnt, and carries err_i alongside the data.

   if_state_t            state_q;
   logic [DataWidth-1:0] pc;
   logic [DataWidth-1:0] instr_q;
   logic [DataWidth-1:0] pc_out_q;
   logic                 new_instr_q;
   logic                 fetch_err_q;
   logic                 advance;

   // fetch_next/jump_en only matter once the current word has been issued
   assign advance = (state_q == IF_ISSUED) && if_fetch_next_i;

`ifdef BETA_IF_MISALIGN_CHECK_EN
   logic misaligned_hit;
   logic misaligned_q;

   beta_if_pc_gen #(.DataWidth(DataWidth), .BootAddr(BootAddr)) u_pc_gen (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .advance_i     (advance),
      .jump_en_i     (if_jump_en_i),
      .jump_target_i (if_jump_target_i),
      .misaligned_o  (misaligned_hit),
      .pc_o          (pc)
   );
`else
   beta_if_pc_gen #(.DataWidth(DataWidth), .BootAddr(BootAddr)) u_pc_gen (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .advance_i     (advance),
      .jump_en_i     (if_jump_en_i),
      .jump_target_i (if_jump_target_i),
      .pc_o          (pc)
   );
`endif

   // Fetch FSM with registered decode-side outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IF_IDLE;
         instr_q     <= '0;
         pc_out_q    <= BootAddr;
         new_instr_q <= 1'b0;
         fetch_err_q <= 1'b0;
`ifdef BETA_IF_MISALIGN_CHECK_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         new_instr_q <= 1'b0;
         case (state_q)
            IF_IDLE: begin
               if (if_fetch_en_i) state_q <= IF_REQ;
            end
            IF_REQ: begin
               if (if_imem_gnt_i) state_q <= IF_WAIT;
            end
            IF_WAIT: begin
               if (if_imem_rvalid_i) begin
                  instr_q     <= if_imem_err_i ? '0 : if_imem_rdata_i;
                  fetch_err_q <= if_imem_err_i;
                  pc_out_q    <= pc;
                  new_instr_q <= 1'b1;
                  state_q     <= IF_ISSUED;
               end
            end
            IF_ISSUED: begin
               if (if_fetch_next_i) begin
`ifdef BETA_IF_MISALIGN_CHECK_EN
                  misaligned_q <= 1'b0;
                  if (misaligned_hit) begin
                     // Trap locally: no bus request, present the bad PC
                     instr_q      <= '0;
                     fetch_err_q  <= 1'b0;
                     pc_out_q     <= if_jump_target_i;
                     misaligned_q <= 1'b1;
                     new_instr_q  <= 1'b1;
                     state_q      <= IF_ISSUED;
                  end else begin
                     state_q <= if_fetch_en_i ? IF_REQ : IF_IDLE;
                  end
`else
                  state_q <= if_fetch_en_i ? IF_REQ : IF_IDLE;
`endif
               end
            end
            default: state_q <= IF_IDLE;
         endcase
      end
   end

   assign if_imem_req_o   = (state_q == IF_REQ);
   assign if_imem_addr_o  = pc;
   assign if_instr_o      = instr_q;
   assign if_pc_o         = pc_out_q;
   assign if_next_pc_o    = pc_out_q + IF_PC_INC;
   assign if_new_instr_o  = new_instr_q;
   assign if_fetch_err_o  = fetch_err_q;
   assign if_stage_busy_o = (state_q == IF_REQ) || (state_q == IF_WAIT);
`ifdef BETA_IF_MISALIGN_CHECK_EN
   assign if_misaligned_o = misaligned_q;
`endif

endmodule

// File: tb/tb_beta_if_stage.sv
// Self-checking bench for beta_if_stage: a memory responder driven from
// tasks, with expected words queued when rvalid is driven and popped when
// the stage raises its new-instruction pulse.
module tb_beta_if_stage;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_fetch_en_i;
   logic        if_imem_req_o;
   logic [31:0] if_imem_addr_o;
   logic        if_imem_gnt_i;
   logic        if_imem_rvalid_i;
   logic [31:0] if_imem_rdata_i;
   logic        if_imem_err_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_next_pc_o;
   logic        if_new_instr_o;
   logic        if_fetch_err_o;
   logic        if_fetch_next_i;
   logic        if_jump_en_i;
   logic [31:0] if_jump_target_i;
   logic        if_stage_busy_o;
`ifdef BETA_IF_MISALIGN_CHECK_EN
   logic        if_misaligned_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];

   // Clock
   always #5 clk = ~clk;

   beta_if_stage dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .if_fetch_en_i    (if_fetch_en_i),
      .if_imem_req_o    (if_imem_req_o),
      .if_imem_addr_o   (if_imem_addr_o),
      .if_imem_gnt_i    (if_imem_gnt_i),
      .if_imem_rvalid_i (if_imem_rvalid_i),
      .if_imem_rdata_i  (if_imem_rdata_i),
      .if_imem_err_i    (if_imem_err_i),
      .if_instr_o       (if_instr_o),
      .if_pc_o          (if_pc_o),
      .if_next_pc_o     (if_next_pc_o),
      .if_new_instr_o   (if_new_instr_o),
      .if_fetch_err_o   (if_fetch_err_o),
      .if_fetch_next_i  (if_fetch_next_i),
      .if_jump_en_i     (if_jump_en_i),
      .if_jump_target_i (if_jump_target_i),
`ifdef BETA_IF_MISALIGN_CHECK_EN
      .if_misaligned_o  (if_misaligned_o),
`endif
      .if_stage_busy_o  (if_stage_busy_o)
   );

   // Advance one cycle; inputs are driven and outputs read 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle fetch_next pulse from "execute"
   task automatic do_next(input logic a_jump, input logic [31:0] a_target);
      if_fetch_next_i  = 1'b1;
      if_jump_en_i     = a_jump;
      if_jump_target_i = a_target;
      tick();
      if_fetch_next_i  = 1'b0;
      if_jump_en_i     = 1'b0;
      if_jump_target_i = 32'h0;
   endtask

   // Memory responder for one transaction plus decode-side checks
   task automatic do_fetch(input logic [31:0] a_addr, input int a_gnt_delay,
                           input logic [31:0] a_rdata, input logic a_err,
                           input logic a_stray_jump);
      int waited;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      waited = 0;
      while (if_imem_req_o !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      n_checks++;
      if (if_imem_req_o !== 1'b1) begin
         $display("FAIL req_timeout: req_o=%b required 1", if_imem_req_o);
         n_fail++;
         return;
      end
      for (int d = 0; d < a_gnt_delay; d++) begin
         n_checks++;
         if (if_imem_req_o !== 1'b1 || if_imem_addr_o !== a_addr || if_new_instr_o !== 1'b0) begin
            $display("FAIL req_hold: req=%b addr=%h new=%b required 1 %h 0",
                     if_imem_req_o, if_imem_addr_o, if_new_instr_o, a_addr);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if (if_imem_addr_o !== a_addr || if_stage_busy_o !== 1'b1) begin
         $display("FAIL req_addr: addr=%h busy=%b required %h 1", if_imem_addr_o, if_stage_busy_o, a_addr);
         n_fail++;
      end
      if_imem_gnt_i = 1'b1;
      tick();
      if_imem_gnt_i = 1'b0;
      n_checks++;
      if (if_imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1 || if_new_instr_o !== 1'b0) begin
         $display("FAIL wait_state: req=%b busy=%b new=%b required 0 1 0",
                  if_imem_req_o, if_stage_busy_o, if_new_instr_o);
         n_fail++;
      end
      if (a_stray_jump) begin
         if_jump_en_i     = 1'b1;
         if_jump_target_i = 32'h0000_0400;
         tick();
         if_jump_en_i     = 1'b0;
         if_jump_target_i = 32'h0;
      end
      if_imem_rvalid_i = 1'b1;
      if_imem_rdata_i  = a_rdata;
      if_imem_err_i    = a_err;
      exp_q.push_back(a_err ? 32'h0 : a_rdata);
      exp_pc_q.push_back(a_addr);
      tick();
      if_imem_rvalid_i = 1'b0;
      if_imem_err_i    = 1'b0;
      if_imem_rdata_i  = 32'h0;
      waited = 0;
      while (if_new_instr_o !== 1'b1 && waited < 5) begin
         tick();
         waited++;
      end
      e_instr = exp_q.pop_front();
      e_pc    = exp_pc_q.pop_front();
      n_checks++;
      if (if_new_instr_o !== 1'b1 || waited != 0) begin
         $display("FAIL new_instr_latency: new=%b after %0d extra cycles required 1 after 0",
                  if_new_instr_o, waited);
         n_fail++;
      end
      n_checks++;
      if (if_instr_o !== e_instr || if_pc_o !== e_pc || if_next_pc_o !== e_pc + 32'd4 ||
          if_fetch_err_o !== a_err || if_stage_busy_o !== 1'b0) begin
         $display("FAIL issue_data: instr=%h pc=%h next=%h err=%b busy=%b required %h %h %h %b 0",
                  if_instr_o, if_pc_o, if_next_pc_o, if_fetch_err_o, if_stage_busy_o,
                  e_instr, e_pc, e_pc + 32'd4, a_err);
         n_fail++;
      end
      tick();
      n_checks++;
      if (if_new_instr_o !== 1'b0 || if_instr_o !== e_instr || if_imem_req_o !== 1'b0) begin
         $display("FAIL pulse_width: new=%b instr=%h req=%b required 0 %h 0",
                  if_new_instr_o, if_instr_o, if_imem_req_o, e_instr);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      n_checks++;
      if (if_imem_req_o !== 1'b0 || if_imem_addr_o !== 32'h80 || if_instr_o !== 32'h0 ||
          if_new_instr_o !== 1'b0 || if_fetch_err_o !== 1'b0 || if_stage_busy_o !== 1'b0) begin
         $display("FAIL reset_state: req=%b addr=%h instr=%h new=%b err=%b busy=%b required 0 00000080 0 0 0 0",
                  if_imem_req_o, if_imem_addr_o, if_instr_o, if_new_instr_o, if_fetch_err_o, if_stage_busy_o);
         n_fail++;
      end
`ifdef BETA_IF_MISALIGN_CHECK_EN
      n_checks++;
      if (if_misaligned_o !== 1'b0) begin
         $display("FAIL reset_misaligned: got %b required 0", if_misaligned_o);
         n_fail++;
      end
`endif
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      if_fetch_en_i = 1'b1;
      do_fetch(32'h80, 0, 32'h0050_0093, 1'b0, 1'b0);
      do_next(1'b0, 32'h0);
      do_fetch(32'h84, 3, 32'h1234_5678, 1'b0, 1'b0);
   endtask

   task automatic test_jump();
      do_next(1'b1, 32'h0000_0200);
      do_fetch(32'h200, 1, 32'hCAFE_0001, 1'b0, 1'b1);
      do_next(1'b0, 32'h0);
      do_fetch(32'h204, 0, 32'hCAFE_0002, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      do_next(1'b1, 32'hFFFF_FFFC);
      do_fetch(32'hFFFF_FFFC, 2, 32'h0000_0013, 1'b0, 1'b0);
      do_next(1'b0, 32'h0);
      do_fetch(32'h0, 0, 32'h0000_0033, 1'b0, 1'b0);
   endtask

   task automatic test_bus_error();
      do_next(1'b0, 32'h0);
      do_fetch(32'h4, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
   endtask

   task automatic test_fetch_en_drop();
      do_next(1'b1, 32'h0000_0500);
      if_fetch_en_i = 1'b0;
      do_fetch(32'h500, 2, 32'h0000_1111, 1'b0, 1'b0);
      do_next(1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (if_imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b0) begin
            $display("FAIL park_idle: req=%b busy=%b required 0 0", if_imem_req_o, if_stage_busy_o);
            n_fail++;
         end
         tick();
      end
      if_fetch_en_i = 1'b1;
      do_fetch(32'h504, 0, 32'h0000_2222, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr;
      addr = 32'h504;
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            addr = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
            do_next(1'b1, addr);
         end else begin
            addr = addr + 32'd4;
            do_next(1'b0, 32'h0);
         end
         do_fetch(addr, $urandom_range(0, 3), $urandom, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      do_next(1'b0, 32'h0);
      if_imem_gnt_i = 1'b1;
      tick();
      if_imem_gnt_i = 1'b0;
      rst_i = 1'b1;
      if_fetch_en_i = 1'b0;
      tick();
      rst_i = 1'b0;
      if_imem_rvalid_i = 1'b1;
      if_imem_rdata_i  = 32'hBAD0_BAD0;
      tick();
      if_imem_rvalid_i = 1'b0;
      if_imem_rdata_i  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (if_new_instr_o !== 1'b0 || if_instr_o !== 32'h0 || if_fetch_err_o !== 1'b0 ||
             if_imem_req_o !== 1'b0 || if_imem_addr_o !== 32'h80 || if_stage_busy_o !== 1'b0) begin
            $display("FAIL reset_mid: new=%b instr=%h err=%b req=%b addr=%h busy=%b required 0 0 0 0 00000080 0",
                     if_new_instr_o, if_instr_o, if_fetch_err_o, if_imem_req_o, if_imem_addr_o, if_stage_busy_o);
            n_fail++;
         end
         tick();
      end
   endtask

   task automatic test_misalign();
      if_fetch_en_i = 1'b1;
      do_fetch(32'h80, 0, 32'h0000_0093, 1'b0, 1'b0);
      do_next(1'b1, 32'h0000_0102);
`ifdef BETA_IF_MISALIGN_CHECK_EN
      n_checks++;
      if (if_new_instr_o !== 1'b1 || if_misaligned_o !== 1'b1 || if_pc_o !== 32'h102 ||
          if_instr_o !== 32'h0 || if_imem_req_o !== 1'b0) begin
         $display("FAIL misalign_trap: new=%b mis=%b pc=%h instr=%h req=%b required 1 1 00000102 0 0",
                  if_new_instr_o, if_misaligned_o, if_pc_o, if_instr_o, if_imem_req_o);
         n_fail++;
      end
      tick();
      n_checks++;
      if (if_new_instr_o !== 1'b0 || if_imem_req_o !== 1'b0 || if_misaligned_o !== 1'b1) begin
         $display("FAIL misalign_hold: new=%b req=%b mis=%b required 0 0 1",
                  if_new_instr_o, if_imem_req_o, if_misaligned_o);
         n_fail++;
      end
      do_next(1'b1, 32'h0000_0300);
      n_checks++;
      if (if_misaligned_o !== 1'b0) begin
         $display("FAIL misalign_clear: got %b required 0", if_misaligned_o);
         n_fail++;
      end
      do_fetch(32'h300, 0, 32'h0000_0444, 1'b0, 1'b0);
`else
      do_fetch(32'h100, 0, 32'h0000_0555, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      rst_i            = 1'b1;
      if_fetch_en_i    = 1'b0;
      if_imem_gnt_i    = 1'b0;
      if_imem_rvalid_i = 1'b0;
      if_imem_rdata_i  = 32'h0;
      if_imem_err_i    = 1'b0;
      if_fetch_next_i  = 1'b0;
      if_jump_en_i     = 1'b0;
      if_jump_target_i = 32'h0;
      test_reset();
      test_basic();
      test_jump();
      test_wrap();
      test_bus_error();
      test_fetch_en_drop();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
         n_fail++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
